// File: rtl/reflet_uart_loader_pkg.sv
// Shared definitions for the UART loader: FSM encodings and bit-timing helpers,
// also used by the debug transmitter.
package reflet_uart_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_LEN  = 2'd0,
        LD_DATA = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    // Bit period in clock cycles, integer-truncated; callers must keep it >= 4.
    function automatic int unsigned bit_period(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_period(input int unsigned p);
        return p / 2;
    endfunction

endpackage

// File: rtl/reflet_uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling, one-cycle byte strobe and stop-bit error pulse.
module reflet_uart_rx_core
    import reflet_uart_loader_pkg::*;
#(
    parameter int unsigned P = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output rx_state_e  state_o
);

    localparam int unsigned HALF = half_period(P);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // Line back high at the start-bit midpoint means it was a glitch.
                if (cnt_q == 32'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == 32'(P - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == 32'(P - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte_o    = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign state_o      = state_q;

endmodule

// File: rtl/reflet_uart_loader.sv
// Boot loader: first received byte is a length N, the next N good bytes are
// written to consecutive addresses from 0 while the CPU is held.
module reflet_uart_loader
    import reflet_uart_loader_pkg::*;
#(
    parameter int unsigned clk_freq  = 1000000,
    parameter int unsigned baud_rate = 9600,
    parameter int unsigned addr_size = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [addr_size-1:0] addr,
    output logic [7:0]           data_out,
    output logic                 write_en,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 frame_error,
    output rx_state_e            dbg_rx_state_o,
    output ld_state_e            dbg_ld_state_o
);

    localparam int unsigned P = bit_period(clk_freq, baud_rate);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    // byte_valid is a one-cycle strobe with no back-pressure: the loader
    // must consume the byte on the cycle it is presented.
    reflet_uart_rx_core #(.P(P)) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx),
        .rx_byte_o   (rx_byte),
        .byte_valid_o(byte_valid),
        .frame_err_o (frame_err),
        .state_o     (dbg_rx_state_o)
    );

    ld_state_e            state_q, state_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           index_q, index_d;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 we_q, we_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LD_LEN;
            len_q   <= '0;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ferr_d  = ferr_q | frame_err;
        case (state_q)
            LD_LEN: begin
                if (byte_valid) begin
                    len_d   = rx_byte;
                    index_d = '0;
                    state_d = (rx_byte == 8'd0) ? LD_DONE : LD_DATA;
                end
            end
            LD_DATA: begin
                if (byte_valid) begin
                    we_d    = 1'b1;
                    data_d  = rx_byte;
                    addr_d  = addr_size'(index_q);
                    index_d = index_q + 8'd1;
                    if (index_q == len_q - 8'd1) state_d = LD_DONE;
                end
            end
            LD_DONE: ;
            default: state_d = LD_LEN;
        endcase
    end

    assign addr           = addr_q;
    assign data_out       = data_q;
    assign write_en       = we_q;
    assign cpu_hold       = (state_q != LD_DONE);
    assign done           = (state_q == LD_DONE);
    assign frame_error    = ferr_q;
    assign dbg_ld_state_o = state_q;

endmodule

// File: tb/tb_reflet_uart_loader.sv
// Bench for reflet_uart_loader: directed load scenarios plus randomized loads,
// checked against a byte-level loader model and an expected-write queue.
module tb_reflet_uart_loader;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int P        = 10;
    localparam int AW       = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [AW-1:0] addr;
    logic [7:0]    data_out;
    logic          write_en, cpu_hold, done, frame_error;
    logic [1:0]    dbg_rx_state, dbg_ld_state;

    reflet_uart_loader #(
        .clk_freq (CLK_FREQ),
        .baud_rate(BAUD),
        .addr_size(AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .addr          (addr),
        .data_out      (data_out),
        .write_en      (write_en),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .frame_error   (frame_error),
        .dbg_rx_state_o(dbg_rx_state),
        .dbg_ld_state_o(dbg_ld_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    bit m_have_len, m_done, m_ferr;
    int m_len, m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Loader semantics at byte level: first good byte is the length,
    // then each good byte lands at the next address until N are written.
    task automatic model_byte(input logic [7:0] b);
        if (m_done) return;
        if (!m_have_len) begin
            m_have_len = 1'b1;
            m_len = int'(b);
            m_idx = 0;
            if (b == 8'd0) m_done = 1'b1;
        end else begin
            exp_q.push_back({8'(m_idx), b});
            m_idx++;
            if (m_idx == m_len) m_done = 1'b1;
        end
    endtask

    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (!reset && write_en) begin
            check("we_not_consecutive", {31'd0, prev_we}, 32'd0);
            obs_q.push_back({addr, data_out});
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr, data_out);
            end else begin
                check("write_addr_data", {16'd0, addr, data_out}, {16'd0, exp_q.pop_front()});
            end
        end
        prev_we <= reset ? 1'b0 : write_en;
    end

    task automatic frame_checks();
        check("pending_writes", exp_q.size(), 0);
        check("done", {31'd0, done}, {31'd0, m_done});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !m_done});
        check("frame_error", {31'd0, frame_error}, {31'd0, m_ferr});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good_stop, input int gap);
        @(negedge clk);
        rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (P) @(negedge clk);
        end
        if (good_stop) model_byte(b);
        else m_ferr = 1'b1;
        rx = good_stop;
        repeat (P) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
        frame_checks();
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        @(negedge clk);
        rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (P) @(negedge clk);
        end
    endtask

    task automatic send_glitch(input int len);
        @(negedge clk);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        repeat (2 * P) @(negedge clk);
        frame_checks();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        m_have_len = 1'b0;
        m_done = 1'b0;
        m_ferr = 1'b0;
        m_len = 0;
        m_idx = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_addr", {24'd0, addr}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        reset = 1'b0;
        repeat (2 * P) @(negedge clk);
        obs_q.delete();
    endtask

    initial begin
        do_reset();

        // Three-byte load, then bytes after done must be ignored.
        send_frame(8'h03, 1'b1, 2 * P);
        send_frame(8'hA1, 1'b1, 2 * P);
        send_frame(8'hB2, 1'b1, 2 * P);
        send_frame(8'hC3, 1'b1, 2 * P);
        check("lit3_count", obs_q.size(), 3);
        check("lit3_w0", {16'd0, obs_q[0]}, 32'h00A1);
        check("lit3_w1", {16'd0, obs_q[1]}, 32'h01B2);
        check("lit3_w2", {16'd0, obs_q[2]}, 32'h02C3);
        check("lit3_done", {31'd0, done}, 32'd1);
        check("lit3_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        send_frame(8'h44, 1'b1, 2 * P);
        check("lit_after_done_count", obs_q.size(), 3);
        check("lit_after_done_done", {31'd0, done}, 32'd1);
        check("lit_after_done_hold", {31'd0, cpu_hold}, 32'd0);

        // Zero-length load.
        do_reset();
        send_frame(8'h00, 1'b1, 2 * P);
        check("lit0_count", obs_q.size(), 0);
        check("lit0_done", {31'd0, done}, 32'd1);
        check("lit0_addr", {24'd0, addr}, 32'd0);

        // Start-bit glitch is ignored.
        do_reset();
        send_glitch(3);
        send_frame(8'h01, 1'b1, 2 * P);
        send_frame(8'h5A, 1'b1, 2 * P);
        check("litg_count", obs_q.size(), 1);
        check("litg_w0", {16'd0, obs_q[0]}, 32'h005A);

        // Framing error does not advance the index.
        do_reset();
        send_frame(8'h02, 1'b1, 2 * P);
        send_frame(8'h11, 1'b0, 2 * P);
        send_frame(8'h22, 1'b1, 2 * P);
        send_frame(8'h33, 1'b1, 2 * P);
        check("litf_ferr", {31'd0, frame_error}, 32'd1);
        check("litf_count", obs_q.size(), 2);
        check("litf_w0", {16'd0, obs_q[0]}, 32'h0022);
        check("litf_w1", {16'd0, obs_q[1]}, 32'h0133);

        // Reset in the middle of the second data byte aborts the load.
        do_reset();
        send_frame(8'h04, 1'b1, 2 * P);
        send_frame(8'h10, 1'b1, 2 * P);
        send_partial(8'h20, 4);
        do_reset();
        send_frame(8'h01, 1'b1, 2 * P);
        send_frame(8'h77, 1'b1, 2 * P);
        check("litr_count", obs_q.size(), 1);
        check("litr_w0", {16'd0, obs_q[0]}, 32'h0077);

        // Randomized loads with occasional bad stop bits and glitches.
        for (int n = 0; n < 16; n++) begin
            int len;
            int good;
            do_reset();
            len = $urandom_range(0, 6);
            send_frame(8'(len), 1'b1, $urandom_range(2 * P, 3 * P));
            good = 0;
            while (good < len) begin
                bit ok;
                ok = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 5) == 0) send_glitch($urandom_range(1, 3));
                send_frame(8'($urandom_range(0, 255)), ok, $urandom_range(2 * P, 3 * P));
                if (ok) good++;
            end
            if ($urandom_range(0, 1) == 1)
                send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 2 * P);
            check("rand_done", {31'd0, done}, 32'd1);
        end

        check("final_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
